// File: rtl/knap_search.sv
// Exhaustive 0/1 knapsack subset search: evaluates every item mask once, in
// ascending order, and keeps the best feasible one. Volume dimension: KNAP_VOLUME_EN.
module knap_search #(
  parameter  int N_ITEMS = 5,
  parameter  int W       = 7,
  localparam int ACC_W   = W + $clog2(N_ITEMS + 1),
  localparam int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [W-1:0]       cfg_value,
  input  logic [W-1:0]       cfg_weight,
  input  logic [W-1:0]       cfg_volume,
  input  logic [ACC_W-1:0]   min_value,
  input  logic [ACC_W-1:0]   max_weight,
  input  logic [ACC_W-1:0]   max_volume,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [ACC_W-1:0]   best_value,
  output logic [N_ITEMS:0]   n_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]         state;
  logic [N_ITEMS-1:0] mask;

  logic [W-1:0]       val_tab [N_ITEMS];
  logic [W-1:0]       wt_tab  [N_ITEMS];
  logic [ACC_W-1:0]   thr_min;
  logic [ACC_W-1:0]   thr_wt;

  logic [ACC_W-1:0]   tot_val;
  logic [ACC_W-1:0]   tot_wt;
  logic               feasible;
  logic               idx_ok;

`ifdef KNAP_VOLUME_EN
  logic [W-1:0]       vol_tab [N_ITEMS];
  logic [ACC_W-1:0]   thr_vol;
  logic [ACC_W-1:0]   tot_vol;
`else
  // Volume ports stay on the interface so both builds share one pinout.
  logic               unused_vol;
  assign unused_vol = ^{cfg_volume, max_volume};
`endif

  function automatic logic [ACC_W-1:0] widen(input logic [W-1:0] x);
    widen = {{(ACC_W - W){1'b0}}, x};
  endfunction

  assign idx_ok = (32'(cfg_idx) < N_ITEMS);
  assign busy   = (state == S_SEARCH);
  assign done   = (state == S_DONE);

  // Stage 0: totals of the current mask, combinational within the cycle
  always_comb begin
    tot_val = '0;
    tot_wt  = '0;
`ifdef KNAP_VOLUME_EN
    tot_vol = '0;
`endif
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        tot_val = tot_val + widen(val_tab[i]);
        tot_wt  = tot_wt  + widen(wt_tab[i]);
`ifdef KNAP_VOLUME_EN
        tot_vol = tot_vol + widen(vol_tab[i]);
`endif
      end
    end
    feasible = (tot_val >= thr_min) && (tot_wt <= thr_wt);
`ifdef KNAP_VOLUME_EN
    feasible = feasible && (tot_vol <= thr_vol);
`endif
  end

  // Stage 1: control, item table and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mask       <= '0;
      found      <= 1'b0;
      best_mask  <= '0;
      best_value <= '0;
      n_valid    <= '0;
      thr_min    <= '0;
      thr_wt     <= '0;
      for (int i = 0; i < N_ITEMS; i++) begin
        val_tab[i] <= '0;
        wt_tab[i]  <= '0;
`ifdef KNAP_VOLUME_EN
        vol_tab[i] <= '0;
`endif
      end
`ifdef KNAP_VOLUME_EN
      thr_vol    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we && idx_ok) begin
            val_tab[cfg_idx] <= cfg_value;
            wt_tab[cfg_idx]  <= cfg_weight;
`ifdef KNAP_VOLUME_EN
            vol_tab[cfg_idx] <= cfg_volume;
`endif
          end
          if (start) begin
            thr_min    <= min_value;
            thr_wt     <= max_weight;
`ifdef KNAP_VOLUME_EN
            thr_vol    <= max_volume;
`endif
            found      <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
            n_valid    <= '0;
            mask       <= '0;
            state      <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (feasible) begin
            n_valid <= n_valid + 1'b1;
            found   <= 1'b1;
            // Strict compare keeps the earliest (lowest) mask on ties.
            if (!found || (tot_val > best_value)) begin
              best_mask  <= mask;
              best_value <= tot_val;
            end
          end
          if (&mask) state <= S_DONE;
          else       mask  <= mask + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
